// File: rtl/wb_queue_if.sv
// Writeback queue bus: producer ports A/M, regfile write port, bypass lookups, halt/drain.
interface wb_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            a_valid;
    logic [4:0]      a_num;
    logic [XLEN-1:0] a_data;
    logic            a_ready;
    logic            m_valid;
    logic [4:0]      m_num;
    logic [XLEN-1:0] m_data;
    logic            m_ready;
    logic            wb_stall;
    logic [4:0]      rd_num;
    logic [XLEN-1:0] rd_data;
    logic            rd_we;
    logic [4:0]      rs_num;
    logic [4:0]      rt_num;
    logic            rs_hit;
    logic [XLEN-1:0] rs_fwd;
    logic            rt_hit;
    logic [XLEN-1:0] rt_fwd;
    logic            halted;
    logic            drained;

    modport slave (
        input  a_valid, a_num, a_data, m_valid, m_num, m_data, wb_stall,
        input  rs_num, rt_num, halted,
        output a_ready, m_ready, rd_num, rd_data, rd_we,
        output rs_hit, rs_fwd, rt_hit, rt_fwd, drained
    );

    modport master (
        output a_valid, a_num, a_data, m_valid, m_num, m_data, wb_stall,
        output rs_num, rt_num, halted,
        input  a_ready, m_ready, rd_num, rd_data, rd_we,
        input  rs_hit, rs_fwd, rt_hit, rt_fwd, drained
    );
endinterface

// File: rtl/wb_queue.sv
// In-order writeback queue in front of the register file with rs/rt bypass and halt drain.
// Optional WBQ_STATS_EN adds retire/drop/stall/full counters reported when drained rises.
module wb_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input logic       clk,
    input logic       rst,
    wb_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [4:0]      num_q  [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [PW:0]     count_q, count_d;

    logic            deq, space, a_acc, m_acc, enq, store;
    logic [4:0]      in_num;
    logic [XLEN-1:0] in_data;
    logic [PW-1:0]   idx;

    assign deq   = (count_q != '0) && !bus.wb_stall;
    // A slot freed by this cycle's retire may be refilled at the same edge.
    assign space = (count_q < (PW+1)'(DEPTH)) || deq;

    assign bus.a_ready = space && !bus.halted;
    assign bus.m_ready = space && !bus.halted && !bus.a_valid;
    assign bus.rd_we   = deq;
    assign bus.rd_num  = num_q[head_q];
    assign bus.rd_data = data_q[head_q];
    assign bus.drained = bus.halted && (count_q == '0);

    assign a_acc   = bus.a_valid && bus.a_ready;
    assign m_acc   = bus.m_valid && bus.m_ready;
    assign enq     = a_acc || m_acc;
    assign in_num  = a_acc ? bus.a_num : bus.m_num;
    assign in_data = a_acc ? bus.a_data : bus.m_data;
    // r0 writes complete the handshake but are never queued.
    assign store   = enq && (in_num != 5'd0);
    assign count_d = count_q + (PW+1)'(store) - (PW+1)'(deq);

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        bus.rs_hit = 1'b0;
        bus.rs_fwd = '0;
        bus.rt_hit = 1'b0;
        bus.rt_fwd = '0;
        idx        = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((PW+1)'(k) < count_q) begin
                if ((bus.rs_num != 5'd0) && (num_q[idx] == bus.rs_num)) begin
                    bus.rs_hit = 1'b1;
                    bus.rs_fwd = data_q[idx];
                end
                if ((bus.rt_num != 5'd0) && (num_q[idx] == bus.rt_num)) begin
                    bus.rt_hit = 1'b1;
                    bus.rt_fwd = data_q[idx];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                num_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (deq) head_q <= head_q + PW'(1);
            if (store) begin
                num_q[tail_q]  <= in_num;
                data_q[tail_q] <= in_data;
                tail_q         <= tail_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

`ifdef WBQ_STATS_EN
    logic [31:0] st_writes_q, st_drops_q, st_mstall_q, st_full_q;
    logic        drained_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_writes_q <= '0;
            st_drops_q  <= '0;
            st_mstall_q <= '0;
            st_full_q   <= '0;
            drained_q   <= 1'b0;
        end else begin
            if (deq) st_writes_q <= st_writes_q + 32'd1;
            if (enq && (in_num == 5'd0)) st_drops_q <= st_drops_q + 32'd1;
            if (bus.m_valid && !bus.m_ready) st_mstall_q <= st_mstall_q + 32'd1;
            if (count_q == (PW+1)'(DEPTH)) st_full_q <= st_full_q + 32'd1;
            drained_q <= bus.drained;
            if (bus.drained && !drained_q) begin
                $display("wbq: writes=%0d drops=%0d mstall=%0d full=%0d",
                         st_writes_q, st_drops_q, st_mstall_q, st_full_q);
            end
        end
    end
`endif
endmodule
